// File: rtl/i2c_master_arbiter.sv
// Round-robin owner select and byte sequencer in front of one i2c_master.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT/HOLD watchdog of TIMEOUT cycles.
module i2c_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              m_start,
  output logic              m_stop,
  output logic              m_rw,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [7:0]        m_rdata,
  input  logic              m_nack
);
  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, STOP} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [PW-1:0]   win, sel;
  logic            found, go, tmo;
  logic [NREQ-1:0] req_ready_n, rsp_valid_n;
  logic [7:0]      rsp_rdata_n, m_wdata_n;
  logic [6:0]      m_addr_n;
  logic            rsp_err_n, m_start_n, m_stop_n, m_rw_n;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return PW'((int'(p) + 1) % NREQ);
  endfunction

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] cnt;

  // watchdog: restarts on every entry to WAIT/HOLD, counts while there
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (state_n != state && (state_n == WAIT || state_n == HOLD))
      cnt <= '0;
    else if (state == WAIT || state == HOLD)
      cnt <= cnt + 32'd1;
  end

  assign tmo = (cnt >= 32'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
`endif

  // round-robin search upward from rr_ptr with wrap-around
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // a new byte comes from the arbitration winner, a follow-on from the owner
  assign sel = (state == HOLD) ? owner : win;

  // next-state and next-output logic; every output leaves a register
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    go          = 1'b0;
    req_ready_n = '0;
    rsp_valid_n = '0;
    rsp_rdata_n = '0;
    rsp_err_n   = 1'b0;
    m_start_n   = 1'b0;
    m_stop_n    = m_stop;
    m_rw_n      = m_rw;
    m_addr_n    = m_addr;
    m_wdata_n   = m_wdata;
    unique case (state)
      IDLE: begin
        m_stop_n = 1'b0;
        go       = found && !m_busy;
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (m_done) begin
          rsp_valid_n = NREQ'(1) << owner;
          rsp_rdata_n = m_rdata;
          rsp_err_n   = m_nack;
          if (m_stop) begin
            state_n  = IDLE;
            rr_ptr_n = nxt(owner);
            m_stop_n = 1'b0;
          end else if (m_nack) begin
            state_n  = STOP;
            m_stop_n = 1'b1;
          end else begin
            state_n  = HOLD;
          end
        end else if (tmo) begin
          rsp_valid_n = NREQ'(1) << owner;
          rsp_err_n   = 1'b1;
          state_n     = STOP;
          m_stop_n    = 1'b1;
        end
      end
      HOLD: begin
        if (req_valid[owner]) begin
          go = 1'b1;
        end else if (tmo) begin
          state_n  = STOP;
          m_stop_n = 1'b1;
        end
      end
      STOP: begin
        m_stop_n = 1'b0;
        rr_ptr_n = nxt(owner);
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (go) begin
      state_n     = ISSUE;
      owner_n     = sel;
      m_start_n   = 1'b1;
      req_ready_n = NREQ'(1) << sel;
      m_rw_n      = req_rw[sel];
      m_addr_n    = req_addr[7*int'(sel) +: 7];
      m_wdata_n   = req_wdata[8*int'(sel) +: 8];
      m_stop_n    = req_last[sel];
    end
  end

  // state, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      m_stop    <= 1'b0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      m_start   <= m_start_n;
      m_stop    <= m_stop_n;
      m_rw      <= m_rw_n;
      m_addr    <= m_addr_n;
      m_wdata   <= m_wdata_n;
    end
  end
endmodule
